fifo_stream_reader: RTL and testbench

//  Read-side consumer for the team's synchronous FIFO. Drives r_en into the FIFO and absorbs its

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_skid_buf2.sv | 50 +++++
 rtl/fifo_stream_reader.sv | 87 ++++++++
 tb/tb_fifo_stream_reader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO package: default data width and the sizing of the read-side
// output skid buffer.
package fifo_pkg;

  // Default word width of the team's synchronous FIFO
  localparam int FIFO_DATA_WIDTH = 4;

  // The output skid buffer holds two words so that one FIFO read latency
  // cycle can be covered without bubbles
  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = 2;

  // Occupancy count of the skid buffer (0..SKID_DEPTH)
  typedef logic [SKID_CNT_W-1:0] skid_cnt_t;

  // Wrap-around increment for the 1-bit head/tail pointers
  function automatic logic ptr_next(input logic ptr);
    return ~ptr;
  endfunction

endpackage

// File: rtl/fifo_skid_buf2.sv
// Two-entry register skid buffer with FIFO ordering. Words are pushed at the
// tail and leave from the head; clear empties the buffer and has priority
// over push and pop.
module fifo_skid_buf2
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [SKID_CNT_W-1:0] count
);

  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  logic                  head_ptr;
  logic                  tail_ptr;

  // Storage, pointers and occupancy; clear drops everything held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem[i] <= '0;
      end
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      count    <= '0;
    end else if (clear) begin
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      count    <= '0;
    end else begin
      if (push) begin
        mem[tail_ptr] <= push_data;
        tail_ptr      <= ptr_next(tail_ptr);
      end
      if (pop) begin
        head_ptr <= ptr_next(head_ptr);
      end
      count <= count + SKID_CNT_W'(push) - SKID_CNT_W'(pop);
    end
  end

  assign head_data = mem[head_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the synchronous FIFO. Issues r_en, absorbs the
// FIFO's one-cycle registered read latency and presents the words as a
// valid/ready stream through a 2-entry skid buffer.
// Optional statistics counters (word_cnt, stall_cnt) are built only when the
// macro FIFO_RD_STATS_EN is defined.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  fifo_r_en,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic [CNT_WIDTH-1:0]  stall_cnt
`endif
);

  logic [SKID_CNT_W-1:0] count;
  logic [SKID_CNT_W:0]   occupancy;
  logic                  inflight;
  logic                  pop;
  logic                  issue;

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;

  // Words held plus the one arriving, minus the one leaving this cycle.
  // Including pop lets a new read go out in the same cycle a word drains,
  // which is what keeps the stream at one word per cycle.
  assign occupancy = {1'b0, count}
                   + {{SKID_CNT_W{1'b0}}, inflight}
                   - {{SKID_CNT_W{1'b0}}, pop};

  assign issue     = rst_n & enable & ~flush & ~fifo_empty
                   & (occupancy < (SKID_CNT_W+1)'(SKID_DEPTH));
  assign fifo_r_en = issue;

  // Remember that a read was accepted so its data is captured next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
    end
  end

  fifo_skid_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .push      (inflight & ~flush),
    .push_data (fifo_r_data),
    .pop       (pop & ~flush),
    .head_data (out_data),
    .count     (count)
  );

`ifdef FIFO_RD_STATS_EN
  // Delivered-word and back-pressure counters, cleared by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt  <= '0;
      stall_cnt <= '0;
    end else if (flush) begin
      word_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      word_cnt  <= word_cnt + CNT_WIDTH'(pop);
      stall_cnt <= stall_cnt + CNT_WIDTH'(out_valid & ~out_ready);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader. A queue-based FIFO model feeds
// the DUT; a reference model tracks the words read and not yet delivered and
// predicts fifo_r_en, out_valid and out_data every cycle.
// Define FIFO_RD_STATS_EN to also exercise the statistics counters.
module tb_fifo_stream_reader;

  localparam int DW = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_r_data = '0;
  logic          fifo_r_en;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
`ifdef FIFO_RD_STATS_EN
  logic [CW-1:0] word_cnt;
  logic [CW-1:0] stall_cnt;
`endif

  int checks = 0;
  int passed = 0;

  int fifo_q[$];
  int exp_q[$];
  bit inf_v = 1'b0;
  int inf_d = 0;
  int got_q[$];
  int exp_word = 0;
  int exp_stall = 0;

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .flush       (flush),
    .fifo_empty  (fifo_empty),
    .fifo_r_data (fifo_r_data),
    .fifo_r_en   (fifo_r_en),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready)
`ifdef FIFO_RD_STATS_EN
    ,
    .word_cnt    (word_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  task automatic applyStimulus(input bit en, input bit rdy, input bit fl);
    enable    = en;
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic pushWord(input int v);
    fifo_q.push_back(v & 15);
    fifo_empty = 1'b0;
  endtask

  task automatic loadFifo(input int n);
    fifo_q.delete();
    for (int i = 1; i <= n; i++) pushWord(i);
    fifo_empty = (fifo_q.size() == 0);
  endtask

  // Asynchronous reset with reads requested; outputs must be quiet at once
  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_fifo_r_en", fifo_r_en, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    exp_q.delete();
    inf_v     = 1'b0;
    exp_word  = 0;
    exp_stall = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock: check at negedge, then advance FIFO and reference model
  task automatic step();
    bit exp_valid, exp_pop, exp_issue, fire, fl, rdy;
    int occ;
    @(negedge clk);
    fl        = flush;
    rdy       = out_ready;
    exp_valid = (exp_q.size() != 0);
    exp_pop   = exp_valid && rdy;
    occ       = exp_q.size() + int'(inf_v) - int'(exp_pop);
    exp_issue = enable && !fl && (fifo_q.size() != 0) && (occ < 2);
    checkOutput("fifo_r_en", fifo_r_en, int'(exp_issue));
    checkOutput("out_valid", out_valid, int'(exp_valid));
    if (exp_valid) checkOutput("out_data", out_data, exp_q[0]);
    checkOutput("cnt_le2", int'(dut.u_skid.count <= 2'd2), 1);
`ifdef FIFO_RD_STATS_EN
    checkOutput("word_cnt", word_cnt, exp_word);
    checkOutput("stall_cnt", stall_cnt, exp_stall);
`endif
    if (out_valid && out_ready) got_q.push_back(int'(out_data));
    fire = fifo_r_en && (fifo_q.size() != 0);
    @(posedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
      exp_word  = 0;
      exp_stall = 0;
    end else begin
      if (exp_pop) void'(exp_q.pop_front());
      if (inf_v) exp_q.push_back(inf_d);
      exp_word  = (exp_word + int'(exp_pop)) % (1 << CW);
      exp_stall = (exp_stall + int'(exp_valid && !rdy)) % (1 << CW);
    end
    inf_v = exp_issue;
    if (exp_issue) inf_d = fifo_q[0];
    if (fire) fifo_r_data = DW'(fifo_q.pop_front());
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Start a directed scenario: preload 1..n, reset, stream with ready high
  task automatic startScenario(input int n);
    got_q.delete();
    loadFifo(n);
    applyStimulus(1'b1, 1'b1, 1'b0);
    doReset();
  endtask

  initial begin
    int r;

    // Startup latency and back-to-back delivery of 1..5
    startScenario(5);
    run(2);
    checkOutput("s1_none_before_lat", got_q.size(), 0);
    run(1);
    checkOutput("s1_first_at_lat", got_q.size(), 1);
    run(4);
    checkOutput("s1_no_bubbles", got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) checkOutput("s1_word", got_q[i], i + 1);

    // Back-pressure for 4 cycles after the first word appears
    startScenario(8);
    run(2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    run(4);
    checkOutput("s2_hold_data", out_data, 1);
    checkOutput("s2_cnt_full", int'(dut.u_skid.count), 2);
    applyStimulus(1'b1, 1'b1, 1'b0);
    run(12);
    checkOutput("s2_count", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) checkOutput("s2_word", got_q[i], i + 1);

    // FIFO runs dry after 3 words, refilled 5 cycles later with 9,10
    startScenario(3);
    run(10);
    checkOutput("s3_drained", got_q.size(), 3);
    pushWord(9);
    pushWord(10);
    run(2);
    checkOutput("s3_refill_lat", got_q.size(), 3);
    run(1);
    checkOutput("s3_refill_first", got_q.size(), 4);
    run(3);
    checkOutput("s3_count", got_q.size(), 5);
    if (got_q.size() >= 5) begin
      checkOutput("s3_w9", got_q[3], 9);
      checkOutput("s3_w10", got_q[4], 10);
    end

    // Flush the cycle after word 4 was issued: 3 and 4 are dropped
    startScenario(8);
    run(4);
    applyStimulus(1'b1, 1'b0, 1'b1);
    run(1);
    checkOutput("s4_valid_drop", out_valid, 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    run(6);
    checkOutput("s4_pre_count_ok", int'(got_q.size() >= 3), 1);
    if (got_q.size() >= 3) checkOutput("s4_next_word", got_q[2], 5);

    // enable low: what is buffered or in flight drains, nothing new is read
    startScenario(8);
    run(4);
    applyStimulus(1'b0, 1'b1, 1'b0);
    run(6);
    checkOutput("s5_count", got_q.size(), 4);
    checkOutput("s5_fifo_left", fifo_q.size(), 4);
    if (got_q.size() >= 4) begin
      checkOutput("s5_w3", got_q[2], 3);
      checkOutput("s5_w4", got_q[3], 4);
    end

    // Reset mid-stream: words already read are lost
    startScenario(8);
    run(4);
    doReset();
    run(6);
    checkOutput("s6_after_reset", int'(got_q.size() >= 3), 1);
    if (got_q.size() >= 3) checkOutput("s6_next_word", got_q[2], 5);

`ifdef FIFO_RD_STATS_EN
    // Statistics: 6 words with 3 stall cycles, then flush clears them
    startScenario(6);
    run(2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    run(3);
    applyStimulus(1'b1, 1'b1, 1'b0);
    run(10);
    checkOutput("s7_word_cnt", word_cnt, 6);
    checkOutput("s7_stall_cnt", stall_cnt, 3);
    applyStimulus(1'b1, 1'b1, 1'b1);
    run(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("s7_word_clr", word_cnt, 0);
    checkOutput("s7_stall_clr", stall_cnt, 0);
`endif

    // Randomized traffic against the reference model
    startScenario(0);
    for (int c = 0; c < 1500; c++) begin
      if (($urandom_range(0, 9) < 6) && (fifo_q.size() < 16)) pushWord($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 7) != 0), ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 39) == 0));
      r = $urandom_range(0, 499);
      if (r == 0) doReset();
      step();
    end
    applyStimulus(1'b1, 1'b1, 1'b0);
    run(40);
    checkOutput("rand_drained", int'(out_valid), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
